// File: rtl/fib_fact_unit.sv
// fib_fact_unit: iterative Fibonacci / factorial engine under a level-based
// request handshake. One ITER edge per step, so a start with operand n
// completes in n edges. result/ovf report the low 16 bits of the true value
// and whether the true value exceeded 16 bits.
module fib_fact_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        FIB,
  input  logic        FACT,
  input  logic [7:0]  operand,
  output logic [15:0] result,
  output logic        FIB_END,
  output logic        FACT_END,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_FIB  = 1'b0,
    OP_FACT = 1'b1
  } op_t;

  state_t      r_state;
  state_t      w_state_nxt;
  op_t         r_op;
  op_t         w_op_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  // Bits [15:0] hold the value modulo 2^16. Bit 16 is a sticky flag meaning
  // "the true value no longer fits in 16 bits"; the modular low part keeps
  // the right residue because + and * commute with truncation.
  logic [16:0] r_a;
  logic [16:0] r_b;
  logic [16:0] w_a_nxt;
  logic [16:0] w_b_nxt;
  logic [15:0] r_result;
  logic        r_ovf;

  logic        w_req_lat;
  logic        w_start;
  logic        w_enter_done;
  logic [16:0] w_fib_sum;
  logic [23:0] w_fact_prod;

  // Request line that owns the current operation; the other one is ignored.
  assign w_req_lat = (r_op == OP_FIB) ? FIB : FACT;
  assign w_start   = FIB | FACT;

  assign w_fib_sum   = {1'b0, r_a[15:0]} + {1'b0, r_b[15:0]};
  assign w_fact_prod = {8'd0, r_a[15:0]} * {16'd0, r_cnt};

  // Next-state logic: start from IDLE, count down in ITER, hold in DONE
  // until the owning request drops; a drop during ITER aborts silently.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = (operand == 8'd0) ? S_DONE : S_ITER;
      end
      S_ITER: begin
        if (!w_req_lat)          w_state_nxt = S_IDLE;
        else if (r_cnt == 8'd1)  w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!w_req_lat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: initial load on start, one recurrence step per
  // ITER edge while the request is still held.
  always_comb begin
    w_op_nxt  = r_op;
    w_cnt_nxt = r_cnt;
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_cnt_nxt = operand;
          if (FIB) begin
            // FIB wins when both requests are high.
            w_op_nxt = OP_FIB;
            w_a_nxt  = 17'd0;
            w_b_nxt  = 17'd1;
          end else begin
            w_op_nxt = OP_FACT;
            w_a_nxt  = 17'd1;
          end
        end
      end
      S_ITER: begin
        if (w_req_lat) begin
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_op == OP_FIB) begin
            w_a_nxt = r_b;
            w_b_nxt = {w_fib_sum[16] | r_a[16] | r_b[16], w_fib_sum[15:0]};
          end else begin
            w_a_nxt = {r_a[16] | (|w_fact_prod[23:16]), w_fact_prod[15:0]};
          end
        end
      end
      default: ;
    endcase
  end

  assign w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Working registers: op, counter and the two recurrence terms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op  <= OP_FIB;
      r_cnt <= 8'd0;
      r_a   <= 17'd0;
      r_b   <= 17'd0;
    end else begin
      r_op  <= w_op_nxt;
      r_cnt <= w_cnt_nxt;
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
    end
  end

  // Visible result/ovf only move on entry to DONE, so an aborted run leaves
  // the previous answer in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= 16'h0000;
      r_ovf    <= 1'b0;
    end else if (w_enter_done) begin
      r_result <= w_a_nxt[15:0];
      r_ovf    <= w_a_nxt[16];
    end
  end

  assign result   = r_result;
  assign ovf      = r_ovf;
  assign busy     = (r_state == S_ITER);
  assign FIB_END  = (r_state == S_DONE) && (r_op == OP_FIB);
  assign FACT_END = (r_state == S_DONE) && (r_op == OP_FACT);

endmodule

// File: tb/tb_fib_fact_unit.sv
// Bench for fib_fact_unit: directed corner cases plus randomized operations,
// checked against a plain-arithmetic reference of F(n) and n!.
module tb_fib_fact_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        FIB = 1'b0;
  logic        FACT = 1'b0;
  logic [7:0]  operand = 8'd0;
  logic [15:0] result;
  logic        FIB_END, FACT_END, busy, ovf;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_res = 16'h0;
  logic        last_ovf = 1'b0;

  fib_fact_unit dut (
    .clk(clk), .rst(rst), .FIB(FIB), .FACT(FACT), .operand(operand),
    .result(result), .FIB_END(FIB_END), .FACT_END(FACT_END),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // True value tracked twice: modulo 2^16 for result, saturated for ovf.
  function automatic void ref_op(input bit fib, input int n,
                                 output logic [15:0] r, output bit o);
    longint cap = 64'd1 << 40;
    longint sa, sb, st;
    int ma, mb, mt;
    if (fib) begin
      ma = 0; mb = 1; sa = 0; sb = 1;
      for (int i = 0; i < n; i++) begin
        mt = (ma + mb) % 65536; ma = mb; mb = mt;
        st = sa + sb; if (st > cap) st = cap; sa = sb; sb = st;
      end
    end else begin
      ma = 1; sa = 1;
      for (int k = 1; k <= n; k++) begin
        ma = (ma * k) % 65536;
        sa = sa * k; if (sa > cap) sa = cap;
      end
    end
    r = ma[15:0];
    o = (sa > 65535);
  endfunction

  task automatic start_req(input bit fib, input bit both, input int n);
    @(negedge clk);
    operand = n[7:0];
    FIB  = fib | both;
    FACT = !fib | both;
  endtask

  // Start edge, then n edges until END; the other request and operand are
  // scrambled meanwhile and must not matter.
  task automatic wait_done(input bit fib, input bit both, input int n, input bit noise);
    int waited = 0, busy_cnt = 0;
    logic [15:0] er; bit eo;
    bit op_fib = fib | both;
    ref_op(op_fib, n, er, eo);
    @(posedge clk); #1;
    if (noise) operand = $urandom;
    while (!(FIB_END | FACT_END) && waited < 300) begin
      if (busy) busy_cnt++;
      if (noise && !both) begin
        if (op_fib) FACT = $urandom; else FIB = $urandom;
      end
      @(posedge clk); #1;
      waited++;
    end
    chk("latency", waited, n);
    chk("busy_cycles", busy_cnt, n);
    chk("fib_end", FIB_END, op_fib);
    chk("fact_end", FACT_END, !op_fib);
    chk("busy_in_done", busy, 0);
    chk("result", result, er);
    chk("ovf", ovf, eo);
    last_res = er; last_ovf = eo;
    // Still holding the request: DONE persists.
    @(posedge clk); #1;
    chk("done_hold", FIB_END | FACT_END, 1);
    @(negedge clk);
    FIB = 1'b0; FACT = 1'b0;
    @(posedge clk); #1;
    chk("end_drop", {FIB_END, FACT_END, busy}, 0);
    chk("result_hold", result, last_res);
  endtask

  task automatic run_op(input bit fib, input bit both, input int n, input bit noise);
    start_req(fib, both, n);
    wait_done(fib, both, n, noise);
  endtask

  // Drop the owning request k edges after the start edge (k < n).
  task automatic abort_op(input bit fib, input int n, input int k);
    start_req(fib, 1'b0, n);
    @(posedge clk); #1;
    repeat (k - 1) @(posedge clk);
    @(negedge clk);
    FIB = 1'b0; FACT = 1'b0;
    @(posedge clk); #1;
    chk("abort_end", {FIB_END, FACT_END, busy}, 0);
    chk("abort_result", result, last_res);
    chk("abort_ovf", ovf, last_ovf);
    @(posedge clk); #1;
    chk("abort_idle", {FIB_END, FACT_END, busy}, 0);
  endtask

  initial begin
    int n, k;
    bit f;
    #12;
    chk("rst_result", result, 0);
    chk("rst_flags", {ovf, FIB_END, FACT_END, busy}, 0);
    @(negedge clk); rst = 1'b1;

    run_op(1, 0, 10, 0);
    run_op(0, 0, 8, 0);
    run_op(0, 0, 9, 1);
    run_op(1, 0, 24, 1);
    run_op(1, 0, 25, 0);
    run_op(1, 0, 0, 0);
    run_op(0, 0, 0, 0);
    run_op(1, 1, 5, 0);
    abort_op(1, 20, 3);

    // Async reset in the middle of a factorial; request stays high across
    // release, so the operation restarts on the first edge afterwards.
    start_req(0, 0, 7);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_flags", {ovf, FIB_END, FACT_END, busy}, 0);
    last_res = 16'h0; last_ovf = 1'b0;
    @(negedge clk); rst = 1'b1;
    wait_done(0, 0, 7, 0);
    chk("restart_5040", result, 5040);

    for (int i = 0; i < 60; i++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 30);
      f = $urandom_range(0, 1);
      if (n >= 3 && $urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, n - 1);
        abort_op(f, n, k);
      end else begin
        run_op(f, $urandom_range(0, 7) == 0, n, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fib_fact_unit.md
FIB_FACT_UNIT -- requirements
Module: fib_fact_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge) and rst (active-low, asynchronous assert).
REQ-002 The ports SHALL be as follows:
- clk  in  1  system clock
- rst  in  1  async active-low reset
- FIB  in  1  Fibonacci request level from control unit
- FACT  in  1  factorial request level from control unit
- operand  in  8  n, unsigned, sampled at start
- result  out  16  F(n) or n!, low 16 bits
- FIB_END  out  1  Fibonacci complete, to control unit
- FACT_END  out  1  factorial complete, to control unit
- busy  out  1  high in ITER
- ovf  out  1  true result exceeded 16'hFFFF

Function
REQ-003 The block SHALL implement states IDLE, ITER and DONE, with internal op (FIB/FACT), cnt[7:0], a[16:0] and b[16:0].
REQ-004 In IDLE with FIB=1 at a clk edge, the block SHALL perform the following in that edge:
- latch op=FIB and cnt=operand;
- set a=0, b=1 and clear ovf;
- go to ITER, or go to DONE if operand==0.
REQ-005 In IDLE with FACT=1 and FIB=0, the block SHALL perform the following in that edge:
- latch op=FACT and cnt=operand;
- set a=1 and clear ovf;
- go to ITER, or go to DONE if operand==0.
REQ-006 If FIB and FACT are both high in IDLE, the block SHALL start Fibonacci only and SHALL ignore FACT.
REQ-007 Each ITER edge for op=FIB SHALL set a<=b, b<=a+b and cnt<=cnt-1.
REQ-008 Each ITER edge for op=FACT SHALL set a<=a*cnt (low 16 bits kept) and cnt<=cnt-1.
REQ-009 The ITER edge on which cnt==1 SHALL move to DONE, giving exactly n ITER edges and a start-to-DONE latency of n edges (0 edges extra for n=0).
REQ-010 On the edge entering DONE, result SHALL load a[15:0].
REQ-011 result SHALL hold its value in IDLE and ITER, and SHALL change only on entry to DONE or on reset.
REQ-012 ovf SHALL be sticky within an operation and SHALL be 1 in DONE iff the mathematical F(n) or n! exceeds 65535.
- Fibonacci: n>=25 sets ovf.
- Factorial: n>=9 sets ovf.
REQ-013 In DONE, FIB_END (op=FIB) or FACT_END (op=FACT) SHALL be high, combinationally from state/op; the other END SHALL be low.
REQ-014 The block SHALL stay in DONE while the latched request input is high, and SHALL go to IDLE on the first edge it is low; END SHALL drop in that IDLE.
REQ-015 If the latched request drops during ITER, the block SHALL abort to IDLE on that edge with no END pulse; result and ovf SHALL be unchanged from before the start.
REQ-016 A change of the other request input during ITER/DONE SHALL be ignored.
REQ-017 busy SHALL be 1 exactly in ITER; FIB_END, FACT_END and busy SHALL never be high simultaneously.
REQ-018 operand changes after the start edge SHALL have no effect.

Reset
REQ-019 While rst=0, independent of clk, the block SHALL hold:
- state=IDLE;
- result=16'h0000, ovf=0;
- FIB_END=0, FACT_END=0, busy=0;
- cnt=0, a=0, b=0.
REQ-020 rst deasserted with FIB or FACT already high SHALL start an operation on the first rising clk edge after release.

Verification
REQ-021 FIB=1, operand=10 -> busy for 10 edges, then FIB_END=1, result=55, ovf=0; FIB=0 -> IDLE on next edge, FIB_END=0.
REQ-022 FACT=1, operand=8 -> result=40320, ovf=0; operand=9 -> result=35200, ovf=1.
REQ-023 FIB, operand=24 -> result=46368, ovf=0; operand=25 -> result=9489, ovf=1.
REQ-024 operand=0 -> for FIB, DONE after the start edge with result=0, no busy cycle; for FACT, result=1, FACT_END=1.
REQ-025 FIB=FACT=1, operand=5 -> result=5, FIB_END=1, FACT_END stays 0; FIB dropped 3 edges into n=20 -> IDLE, no END, result unchanged.
REQ-026 rst=0 mid-ITER (FACT, n=7, edge 4) -> result=0, busy=0, END=0 immediately, before the next clk edge; restart after release yields 5040.
